// File: rtl/wb_stage_pkg.sv
// Shared sizes and types for the writeback stage: register count, word and
// register-address types, the writeback request struct and the source enum.
package common;

    localparam int CREG_NUM = 32;
    localparam int CREG_AW  = $clog2(CREG_NUM);

    typedef logic [31:0]        word_t;
    typedef logic [CREG_AW-1:0] creg_addr_t;

    typedef struct packed {
        creg_addr_t dst;
        word_t      data;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set by issue and
// cleared by the regfile write; a coincident set on the same register wins.
module wb_scoreboard
    import common::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                issue_valid,
    input  creg_addr_t          issue_dst,
    input  logic                commit_valid,
    input  creg_addr_t          commit_dst,
    output logic [CREG_NUM-1:0] busy
);

    localparam logic [CREG_NUM-1:0] ONE_HOT0 = {{(CREG_NUM-1){1'b0}}, 1'b1};

    logic [CREG_NUM-1:0] set_vec;
    logic [CREG_NUM-1:0] clr_vec;
    logic [CREG_NUM-1:0] busy_next;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        set_vec   = '0;
        clr_vec   = '0;
        if (issue_valid)  set_vec = ONE_HOT0 << issue_dst;
        if (commit_valid) clr_vec = ONE_HOT0 << commit_dst;
        // Applying the set after the clear gives a newer producer priority.
        busy_next    = (busy & ~clr_vec) | set_vec;
        busy_next[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: round-robin merge of ALU and load results into one
// registered regfile write, plus busy scoreboard. Optional bypass: WB_BYPASS_EN.
module wb_stage
    import common::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  creg_addr_t          alu_dst,
    input  word_t               alu_data,
    output logic                alu_ready,
    input  logic                mem_valid,
    input  creg_addr_t          mem_dst,
    input  word_t               mem_data,
    output logic                mem_ready,
    input  logic                issue_valid,
    input  creg_addr_t          issue_dst,
    output logic                wvalid,
    output creg_addr_t          wa,
    output word_t               wd,
    output logic [CREG_NUM-1:0] busy
`ifdef WB_BYPASS_EN
    ,
    output logic                byp_valid,
    output creg_addr_t          byp_dst,
    output word_t               byp_data
`endif
);

    wb_src_e last_grant;
    logic    alu_grant;
    logic    mem_grant;
    logic    grant;
    logic    write_en;
    wb_req_t sel_req;

    // Grants are forced low during reset so no handshake completes then.
    always_comb begin
        alu_grant = !reset && alu_valid && (!mem_valid || last_grant == WB_SRC_MEM);
        mem_grant = !reset && mem_valid && (!alu_valid || last_grant == WB_SRC_ALU);
        grant     = alu_grant || mem_grant;
        sel_req   = mem_grant ? '{dst: mem_dst, data: mem_data}
                              : '{dst: alu_dst, data: alu_data};
        write_en  = grant && (sel_req.dst != '0);
    end

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= WB_SRC_ALU;
            wvalid     <= 1'b0;
            wa         <= '0;
            wd         <= '0;
        end else begin
            if (grant) last_grant <= mem_grant ? WB_SRC_MEM : WB_SRC_ALU;
            wvalid <= write_en;
            // Address and data hold when nothing is written.
            if (write_en) begin
                wa <= sel_req.dst;
                wd <= sel_req.data;
            end
        end
    end

    wb_scoreboard u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_dst    (issue_dst),
        .commit_valid (wvalid),
        .commit_dst   (wa),
        .busy         (busy)
    );

`ifdef WB_BYPASS_EN
    assign byp_valid = write_en;
    assign byp_dst   = sel_req.dst;
    assign byp_data  = sel_req.data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; bypass checks are compiled in
// when WB_BYPASS_EN is defined.
module tb_wb_stage;
    import common::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                alu_valid, mem_valid, issue_valid;
    creg_addr_t          alu_dst, mem_dst, issue_dst;
    word_t               alu_data, mem_data;
    logic                alu_ready, mem_ready;
    logic                wvalid;
    creg_addr_t          wa;
    word_t               wd;
    logic [CREG_NUM-1:0] busy;
`ifdef WB_BYPASS_EN
    logic                byp_valid;
    creg_addr_t          byp_dst;
    word_t               byp_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_dst     (alu_dst),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_dst     (mem_dst),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .wvalid      (wvalid),
        .wa          (wa),
        .wd          (wd),
        .busy        (busy)
`ifdef WB_BYPASS_EN
        ,
        .byp_valid   (byp_valid),
        .byp_dst     (byp_dst),
        .byp_data    (byp_data)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        bit         exp_mem;
        creg_addr_t exp_dst;
        word_t      exp_data;
        int         alu_k, mem_k;

        reset = 1'b1;
        alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'h1234;
        mem_valid = 1'b0; mem_dst = '0;   mem_data = '0;
        issue_valid = 1'b0; issue_dst = '0;

        // Reset: outputs cleared and ready held low despite a valid.
        settle();
        check("rst_alu_ready", alu_ready, 0);
        tick(); tick();
        check("rst_wvalid", wvalid, 0);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_ready2", alu_ready, 0);
`ifdef WB_BYPASS_EN
        check("rst_byp_valid", byp_valid, 0);
`endif

        // Single ALU write to r5.
        reset = 1'b0;
        settle();
        check("t1_alu_ready", alu_ready, 1);
        check("t1_mem_ready", mem_ready, 0);
`ifdef WB_BYPASS_EN
        check("t1_byp_valid", byp_valid, 1);
        check("t1_byp_dst", byp_dst, 5);
        check("t1_byp_data", byp_data, 32'h1234);
`endif
        tick();
        alu_valid = 1'b0;
        check("t1_wvalid", wvalid, 1);
        check("t1_wa", wa, 5);
        check("t1_wd", wd, 32'h1234);
        tick();
        check("t1_wvalid_off", wvalid, 0);
        check("t1_wa_hold", wa, 5);

        // Conflict from reset: MEM first, then ALU.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        alu_valid = 1'b1; alu_dst = 5'd3; alu_data = 32'hA;
        mem_valid = 1'b1; mem_dst = 5'd4; mem_data = 32'hB;
        settle();
        check("t2_mem_ready", mem_ready, 1);
        check("t2_alu_ready", alu_ready, 0);
        tick();
        mem_valid = 1'b0;
        check("t2_wa_first", wa, 4);
        check("t2_wd_first", wd, 32'hB);
        check("t2_alu_ready2", alu_ready, 1);
        tick();
        alu_valid = 1'b0;
        check("t2_wvalid_second", wvalid, 1);
        check("t2_wa_second", wa, 3);
        check("t2_wd_second", wd, 32'hA);
        tick();

        // Continuous contention: grants alternate MEM, ALU, MEM, ...
        alu_k = 0; mem_k = 0;
        alu_valid = 1'b1; alu_dst = 5'd1; alu_data = 32'h100;
        mem_valid = 1'b1; mem_dst = 5'd2; mem_data = 32'h200;
        for (int i = 0; i < 6; i++) begin
            exp_mem  = (i % 2 == 0);
            exp_dst  = exp_mem ? 5'd2 : 5'd1;
            exp_data = exp_mem ? 32'h200 + 32'(mem_k) : 32'h100 + 32'(alu_k);
            settle();
            check($sformatf("t3_mem_ready_%0d", i), mem_ready, exp_mem);
            check($sformatf("t3_alu_ready_%0d", i), alu_ready, !exp_mem);
            tick();
            if (exp_mem) begin mem_k++; mem_data = 32'h200 + 32'(mem_k); end
            else         begin alu_k++; alu_data = 32'h100 + 32'(alu_k); end
            check($sformatf("t3_wa_%0d", i), wa, exp_dst);
            check($sformatf("t3_wd_%0d", i), wd, exp_data);
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();

        // Load to r0: handshake completes, no write, no busy change.
        mem_valid = 1'b1; mem_dst = 5'd0; mem_data = 32'hFFFF;
        settle();
        check("t4_mem_ready", mem_ready, 1);
`ifdef WB_BYPASS_EN
        check("t4_byp_valid", byp_valid, 0);
`endif
        tick();
        mem_valid = 1'b0;
        check("t4_wvalid", wvalid, 0);
        check("t4_wa_hold", wa, 1);
        check("t4_busy", busy, 0);

        // Scoreboard: issue r7, ALU writes r7 two cycles later.
        issue_valid = 1'b1; issue_dst = 5'd7;
        settle();
        check("t5_busy_pre", busy[7], 0);
        tick();
        issue_valid = 1'b0;
        check("t5_busy_a1", busy[7], 1);
        tick();
        alu_valid = 1'b1; alu_dst = 5'd7; alu_data = 32'h77;
        check("t5_busy_a2", busy[7], 1);
        tick();
        alu_valid = 1'b0;
        check("t5_wa", wa, 7);
        check("t5_busy_wv", busy[7], 1);
        tick();
        check("t5_busy_clear", busy[7], 0);

        // Same again, with a new issue to r7 in the wvalid cycle.
        issue_valid = 1'b1; issue_dst = 5'd7;
        tick();
        issue_valid = 1'b0;
        tick();
        alu_valid = 1'b1; alu_dst = 5'd7; alu_data = 32'h78;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_dst = 5'd7;
        check("t5b_wvalid", wvalid, 1);
        tick();
        issue_valid = 1'b0;
        check("t5b_busy_kept", busy[7], 1);
        tick();
        check("t5b_busy_still", busy[7], 1);

        // Reset in the wvalid cycle discards the write and clears busy.
        alu_valid = 1'b1; alu_dst = 5'd6; alu_data = 32'h66;
        tick();
        alu_valid = 1'b1; alu_dst = 5'd9; alu_data = 32'h99;
        check("t6_wvalid", wvalid, 1);
        reset = 1'b1;
        settle();
        check("t6_alu_ready_rst", alu_ready, 0);
`ifdef WB_BYPASS_EN
        check("t6_byp_valid_rst", byp_valid, 0);
`endif
        tick();
        check("t6_wvalid_rst", wvalid, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_wa_rst", wa, 0);
        reset = 1'b0;
        alu_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
